// File: rtl/gb_ifmap_fetch.sv
// gb_ifmap_fetch: burst reader for the ifmap global buffer with a skid FIFO feeding a valid/ready stream
// Ports: clk/reset (async active-low); start/base_addr/num_words launch a burst; busy/done status;
// gb_read_req/gb_r_addr/gb_r_data form the 1-cycle-latency GB read port; out_valid/out_data/out_last/out_ready
// form the stream toward the PE array.
module gb_ifmap_fetch #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BITWIDTH-1:0] base_addr,
    input  logic [ADDR_BITWIDTH:0]   num_words,
    output logic                     busy,
    output logic                     done,
    output logic                     gb_read_req,
    output logic [ADDR_BITWIDTH-1:0] gb_r_addr,
    input  logic [DATA_BITWIDTH-1:0] gb_r_data,
    output logic                     out_valid,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic                     out_last,
    input  logic                     out_ready
);
    localparam int AW = ADDR_BITWIDTH;
    localparam int NW = ADDR_BITWIDTH + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t            state_q, state_d;
    logic [AW-1:0]     base_q, base_d, addr_q, addr_d;
    logic [NW-1:0]     num_q, num_d, issued_q, issued_d, popped_q, popped_d;
    logic              req_q, req_d, prev_q;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW:0]       occ;
    logic              push, pop, room;
    logic [DATA_BITWIDTH-1:0] mem_q [FIFO_DEPTH];
    // prev_q marks the cycle gb_r_data carries a requested word; only then is it captured
    assign push      = prev_q;
    assign pop       = out_valid & out_ready;
    // count words already queued plus both reads still in the GB pipeline, so the FIFO never overflows
    assign occ       = {1'b0, cnt_q} + (CW+1)'(prev_q) + (CW+1)'(req_q);
    assign room      = occ < (CW+1)'(FIFO_DEPTH);
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign gb_read_req = req_q;
    assign gb_r_addr = addr_q;
    assign out_valid = cnt_q != '0;
    assign out_data  = mem_q[rd_q];
    assign out_last  = out_valid && (popped_q == num_q - NW'(1));
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        num_d    = num_q;
        issued_d = issued_q;
        popped_d = pop ? popped_q + NW'(1) : popped_q;
        req_d    = 1'b0;
        addr_d   = addr_q;
        wr_d     = push ? wr_q + PW'(1) : wr_q;
        rd_d     = pop ? rd_q + PW'(1) : rd_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        case (state_q)
            IDLE: if (start) begin
                base_d   = base_addr;
                num_d    = num_words;
                popped_d = '0;
                state_d  = (num_words == '0) ? DONE : FETCH;
                req_d    = num_words != '0;
                addr_d   = base_addr;
                issued_d = (num_words == '0) ? '0 : NW'(1);
            end
            FETCH: if (issued_q == num_q) state_d = DRAIN;
                else if (room) begin
                    req_d    = 1'b1;
                    addr_d   = base_q + issued_q[AW-1:0];
                    issued_d = issued_q + NW'(1);
                end
            DRAIN: if (pop && popped_q == num_q - NW'(1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            req_q    <= 1'b0;
            prev_q   <= 1'b0;
            addr_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            req_q    <= req_d;
            prev_q   <= req_q;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= gb_r_data;
    end
endmodule
